// File: rtl/d_counter_ctrl_if.sv
// Host and counter-side signal bundle for d_counter_ctrl.
// D_CTRL_SNAPSHOT_EN adds the Snap capture output.
interface d_counter_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  Start;
    logic                  Stop;
    logic                  Mode;
    logic [WIDTH-1:0]      TC;
    logic [PRESCALE_W-1:0] Prescale;
    logic [WIDTH-1:0]      Q;
    logic                  CNT_EN;
    logic                  CNT_CLR;
    logic                  Ready;
    logic                  Busy;
    logic                  Done;
    logic                  Ack;
    logic                  Overrun;
`ifdef D_CTRL_SNAPSHOT_EN
    logic [WIDTH-1:0]      Snap;

    modport master (
        output Start, Stop, Mode, TC, Prescale, Q, Ack,
        input  CNT_EN, CNT_CLR, Ready, Busy, Done, Overrun,
        input  Snap
    );
    modport slave (
        input  Start, Stop, Mode, TC, Prescale, Q, Ack,
        output CNT_EN, CNT_CLR, Ready, Busy, Done, Overrun,
        output Snap
    );
`else
    modport master (
        output Start, Stop, Mode, TC, Prescale, Q, Ack,
        input  CNT_EN, CNT_CLR, Ready, Busy, Done, Overrun
    );
    modport slave (
        input  Start, Stop, Mode, TC, Prescale, Q, Ack,
        output CNT_EN, CNT_CLR, Ready, Busy, Done, Overrun
    );
`endif
endinterface

// File: rtl/d_counter_ctrl.sv
// Interval-timer sequencer for the D flip-flop counter (one-shot/periodic).
// Optional D_CTRL_SNAPSHOT_EN captures Q on Stop and TC on one-shot events.
module d_counter_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input logic             CLK,
    input logic             Clear_n,
    d_counter_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    logic [1:0]            state;
    logic [WIDTH-1:0]      tc_reg;
    logic [PRESCALE_W-1:0] pre_reg;
    logic [PRESCALE_W-1:0] presc;
    logic                  mode_reg;
    logic                  done;
    logic                  overrun;
    logic                  accept;
    logic                  tc_hit;
    logic                  ev;
    logic                  tick;

    always_comb begin
        accept = (state == IDLE) && bus.Start && !bus.Stop;
        tc_hit = (state == RUN) && (bus.Q == tc_reg);
        ev     = tc_hit && !bus.Stop;
        tick   = (state == RUN) && !tc_hit && (presc == pre_reg);
    end

    // Stop suppresses both strobes so an abort never moves the counter
    assign bus.CNT_EN  = tick && !bus.Stop;
    assign bus.CNT_CLR = (state == CLEAR) && !bus.Stop;
    assign bus.Ready   = (state == IDLE);
    assign bus.Busy    = (state != IDLE);
    assign bus.Done    = done;
    assign bus.Overrun = overrun;

    always_ff @(posedge CLK or negedge Clear_n) begin
        if (!Clear_n) begin
            state    <= IDLE;
            presc    <= '0;
            tc_reg   <= '0;
            pre_reg  <= '0;
            mode_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= CLEAR;
                        tc_reg   <= bus.TC;
                        pre_reg  <= bus.Prescale;
                        mode_reg <= bus.Mode;
                    end
                end
                CLEAR: begin
                    presc <= '0;
                    state <= bus.Stop ? IDLE : RUN;
                end
                RUN: begin
                    if (bus.Stop) begin
                        state <= IDLE;
                    end else if (tc_hit) begin
                        state <= mode_reg ? CLEAR : IDLE;
                    end else if (tick) begin
                        presc <= '0;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ack arriving with an event keeps Done and leaves Overrun alone
    always_ff @(posedge CLK or negedge Clear_n) begin
        if (!Clear_n) begin
            done    <= 1'b0;
            overrun <= 1'b0;
        end else if (ev) begin
            done <= 1'b1;
            if (done && !bus.Ack)
                overrun <= 1'b1;
        end else if (bus.Ack) begin
            done    <= 1'b0;
            overrun <= 1'b0;
        end
    end

`ifdef D_CTRL_SNAPSHOT_EN
    logic [WIDTH-1:0] snap;

    always_ff @(posedge CLK or negedge Clear_n) begin
        if (!Clear_n)
            snap <= '0;
        else if ((state == RUN) && bus.Stop)
            snap <= bus.Q;
        else if (ev && !mode_reg)
            snap <= tc_reg;
    end

    assign bus.Snap = snap;
`endif
endmodule

// File: doc/d_counter_ctrl.md
Name: d_counter_ctrl

Overview:
- Sequencer for the team's 8-bit D flip-flop counter (D_counter; ports CLK, D = count enable, Clear).
- Turns it into a programmable interval timer: one-shot or periodic, with a prescaled count enable, terminal-count detection from the fed-back Q, and a sticky Done/Ack handshake toward the host.
- Integration: CNT_EN drives D_counter.D, CNT_CLR drives D_counter.Clear, D_counter.Q returns on Q.
- Counter contract: synchronous clear; Clear has priority over D.

Parameters:
WIDTH, 8, counter/terminal-count width
PRESCALE_W, 4, width of prescale divider field

Ports:
CLK  in  1  system clock, rising edge
Clear_n  in  1  asynchronous active-low reset
Start  in  1  start request; accepted only when Ready=1
Stop  in  1  abort request
Mode  in  1  0 = one-shot, 1 = periodic; captured on accepted Start
TC  in  WIDTH  terminal count; captured on accepted Start
Prescale  in  PRESCALE_W  count enable every Prescale+1 cycles; captured on accepted Start
Q  in  WIDTH  counter value fed back
CNT_EN  out  1  count enable to counter
CNT_CLR  out  1  synchronous clear to counter
Ready  out  1  controller idle, Start will be accepted
Busy  out  1  inverse of Ready
Done  out  1  terminal count reached; sticky until Ack
Ack  in  1  clears Done and Overrun
Overrun  out  1  periodic event occurred while Done still set; sticky until Ack

Behaviour:
- Reset (Clear_n=0, async): state IDLE, prescaler=0, captured regs=0, Done=0, Overrun=0. CNT_EN=0, CNT_CLR=0, Ready=1, Busy=0.
- States: IDLE, CLEAR, RUN.
- IDLE:
  - Ready=1.
  - Start=1 and Stop=0 -> CLEAR; TC, Prescale and Mode are captured at that edge.
  - Start=1 with Stop=1 -> stay IDLE.
- CLEAR (one cycle):
  - CNT_CLR=1, CNT_EN=0, prescaler forced to 0.
  - Next state RUN.
- RUN:
  - CNT_CLR=0.
  - Terminal event when Q==TC_reg (equality only). CNT_EN=0 in the event cycle.
  - Otherwise CNT_EN=1 in the cycle where prescaler==Prescale_reg, and the prescaler wraps to 0; else the prescaler increments.
  - On event: Done<=1. Next state IDLE if Mode_reg=0; CLEAR if Mode_reg=1.
- Timing: Q=k is visible in RUN cycle k*(P+1), counted from 0.
  - Done rises at edge number TC*(P+1)+2 after the Start-accept edge.
  - Periodic period = TC*(P+1)+2 cycles.
  - TC=0: event in the first RUN cycle; CNT_EN never asserts.
- Overrun: event while Done=1 and Ack=0 -> Overrun<=1 (Done stays 1).
- Ack:
  - Clears Done and Overrun at the next edge.
  - Ack coincident with an event: Done<=1, Overrun unchanged (not set).
- Stop in CLEAR or RUN:
  - Next state IDLE; CNT_EN=0 in the Stop cycle.
  - No Done, even if an event coincides (Stop has priority).
  - The counter is not cleared.
- Start while Busy: ignored; captured registers unchanged.
- Encoding:
  - CNT_EN and CNT_CLR are combinational from state, prescaler and Q.
  - Ready and Busy decode state.
  - Done and Overrun are registered.
- Reset mid-operation: immediate return to reset values; the counter is left as-is.

Optional Feature:
D_CTRL_SNAPSHOT_EN
- Defined:
  - Adds output Snap [WIDTH-1:0], reset 0.
  - When Stop is accepted in RUN, Snap<=Q at that edge.
  - On a one-shot event, Snap<=TC_reg.
  - Otherwise holds.
- Undefined: Snap port and its register absent; all other behaviour identical.

Test Plan:
- Pulse Clear_n low in RUN with Q=3, Done=1 -> immediately Ready=1, Busy=0, Done=0, Overrun=0, CNT_EN=0, CNT_CLR=0.
- One-shot: TC=5, Prescale=0, Start at edge 0 -> CNT_CLR high in cycle 1; CNT_EN high 5 consecutive cycles; Done=1 at edge 7; Ready=1 from edge 7; Q holds at 5.
- Periodic: TC=3, Prescale=1, no Ack -> Done=1 at edge 8; CNT_CLR each 8 cycles; Overrun=1 at edge 16. Ack at edge 17 -> Done=0, Overrun=0.
- Boundaries:
  - TC=0 one-shot -> Done=1 at edge 2, CNT_EN never 1.
  - TC=255, Prescale=0 -> Done=1 at edge 257, Q=255, no wrap to 0.
- Stop while Q=2 in RUN -> IDLE next edge, Done stays 0, Q stays 2 (Snap=2 with D_CTRL_SNAPSHOT_EN). Start during RUN ignored: TC change has no effect.
- Periodic TC=2, Prescale=0 with Ack asserted exactly on the second event cycle -> Done remains 1, Overrun remains 0.
